ad9228_capture_ctrl: RTL and testbench
======================================

// Module: ad9228_capture_ctrl
//
// PURPOSE
//  Sequences a block acquisition from the NUM_CH deserialiser cores of one AD9228.
//  Arm/trigger/abort control; counts accepted samples up to a programmed length.
//  Snapshots all channel words on each sample strobe.
//  Streams the words out one channel per beat on a valid/ready stream toward the readout FIFO.
//
// PARAMETERS
//  DATA_WIDTH  12  bits per ADC word
//  NUM_CH      4   channels per ADC (AD9228 quad)
//  CNT_WIDTH   16  width of sample counter / num_samples
//
// PORTS
//  clk          in   1                    sampling clock; only clock in block
//  rstn         in   1                    synchronous reset, active low
//  ch_data      in   NUM_CH*DATA_WIDTH    deserialised words; ch0 in LSBs; already in clk domain
//  sample_strb  in   1                    1-cycle pulse: ch_data holds a new sample
//  arm          in   1                    1-cycle pulse: start acquisition setup
//  trigger      in   1                    level; sampled only in ARMED
//  abort        in   1                    1-cycle pulse: cancel acquisition
//  num_samples  in   CNT_WIDTH            samples per acquisition; latched on accepted arm
//  m_tdata      out  DATA_WIDTH           current channel word
//  m_tchan      out  $clog2(NUM_CH)       channel index of m_tdata
//  m_tvalid     out  1                    stream valid
//  m_tready     in   1                    stream ready
//  m_tlast      out  1                    last beat of acquisition
//  busy         out  1                    state is ARMED, CAPTURE or DRAIN
//  done         out  1                    high in DONE state
//  overflow     out  1                    sticky: a strobe was dropped
//
// BEHAVIOUR
//  - Reset (rstn=0 at posedge clk):
//    - state=IDLE; snapshot and snap_full, ch_idx and sample_cnt cleared.
//    - All outputs 0.
//    - Reset mid-acquisition discards any pending snapshot.
//  - FSM states: IDLE, ARMED, CAPTURE, DRAIN, DONE.
//    - abort has priority in every state: next state IDLE, snap_full=0, m_tvalid=0.
//  - arm:
//    - Accepted in IDLE/DONE only, and only if num_samples!=0; otherwise ignored.
//    - On accept: latch num_samples, clear sample_cnt, overflow, done; state -> ARMED.
//  - ARMED:
//    - trigger=1 -> CAPTURE.
//    - A sample_strb in the same cycle as trigger IS captured.
//  - CAPTURE, on sample_strb:
//    - Snapshot empty, or being freed this cycle by the last-channel handshake:
//      - Latch ch_data, set snap_full, sample_cnt++.
//    - Otherwise: drop sample, set overflow; sample_cnt unchanged.
//    - When sample_cnt reaches num_samples: state -> DRAIN.
//    - Strobes in DRAIN/DONE/IDLE are ignored; they do not set overflow.
//  - Output serialiser:
//    - m_tvalid = snap_full.
//    - m_tdata = snapshot[ch_idx]; m_tchan = ch_idx.
//    - On m_tvalid & m_tready: ch_idx++.
//    - At ch_idx=NUM_CH-1: ch_idx=0 and snap_full=0.
//    - m_tdata, m_tchan and m_tlast are held stable while m_tvalid & !m_tready.
//    - Latency: strobe at cycle N -> m_tvalid=1 with channel 0 at N+1.
//    - Minimum NUM_CH cycles per sample at full ready.
//  - m_tlast = 1 only on beat ch=NUM_CH-1 of sample number num_samples.
//  - DRAIN -> DONE on the handshake of the m_tlast beat.
//  - DONE holds until arm or abort; busy=0 and done=1 in DONE.
//  - sample_cnt never wraps; num_samples = 2^CNT_WIDTH-1 is the maximum.
//
// TESTING
//  - NUM_CH=4, num_samples=3, ready=1, strobe every 6 cycles, ch_data={4'hD,C,B,A}
//    -> 12 beats, chan 0..3 repeating; tlast on beat 12; done=1; overflow=0.
//  - Strobe every 2 cycles, num_samples=4
//    -> overflow=1; only accepted samples streamed; 4 full samples before done.
//  - Strobe coincident with last-channel handshake
//    -> sample accepted, overflow stays 0, ch0 of new sample on next cycle.
//  - m_tready held 0 for 10 cycles mid-sample
//    -> tdata/tchan stable throughout; stream resumes at the stalled channel.
//  - abort during CAPTURE with snap_full=1
//    -> next cycle IDLE, tvalid=0, busy=0; re-arm works.
//  - arm with num_samples=0 -> stays IDLE.
//  - rstn=0 mid-DRAIN -> all outputs 0 on next cycle.

Source files
------------

// File: rtl/ad9228_capture_ctrl.sv
// ad9228_capture_ctrl
// Block acquisition sequencer for the deserialised channels of one AD9228.
// Handles arm/trigger/abort and counts accepted samples up to a programmed length.
// Each accepted strobe snapshots every channel word, and the words stream out
// one channel per beat on a valid/ready interface.
module ad9228_capture_ctrl #(
    parameter int DATA_WIDTH = 12,
    parameter int NUM_CH     = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
    input  logic                         sample_strb,
    input  logic                         arm,
    input  logic                         trigger,
    input  logic                         abort,
    input  logic [CNT_WIDTH-1:0]         num_samples,
    output logic [DATA_WIDTH-1:0]        m_tdata,
    output logic [$clog2(NUM_CH)-1:0]    m_tchan,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic                         m_tlast,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_CAPTURE = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                               state_q, state_d;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]    snap_q, snap_d;
    logic                                 snap_full_q, snap_full_d;
    logic [CH_W-1:0]                      ch_idx_q, ch_idx_d;
    logic [CNT_WIDTH-1:0]                 sample_cnt_q, sample_cnt_d;
    logic [CNT_WIDTH-1:0]                 num_q, num_d;
    logic                                 overflow_q, overflow_d;

    logic beat;
    logic last_ch;
    logic free_now;
    logic window;

    // Next-state logic: serialiser advance, sample acceptance, then arm and abort overrides.
    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        snap_full_d  = snap_full_q;
        ch_idx_d     = ch_idx_q;
        sample_cnt_d = sample_cnt_q;
        num_d        = num_q;
        overflow_d   = overflow_q;

        beat     = snap_full_q & m_tready;
        last_ch  = (ch_idx_q == LAST_CH);
        // The snapshot becomes free in the same cycle its final channel is taken,
        // so a strobe arriving on that cycle can still be captured.
        free_now = beat & last_ch;
        window   = (state_q == S_CAPTURE) | ((state_q == S_ARMED) & trigger);

        if (beat) begin
            if (last_ch) begin
                ch_idx_d    = '0;
                snap_full_d = 1'b0;
            end else begin
                ch_idx_d = ch_idx_q + CH_W'(1);
            end
        end

        if ((state_q == S_ARMED) && trigger) begin
            state_d = S_CAPTURE;
        end

        if (window && sample_strb) begin
            if (!snap_full_q || free_now) begin
                snap_d       = ch_data;
                snap_full_d  = 1'b1;
                ch_idx_d     = '0;
                sample_cnt_d = sample_cnt_q + CNT_WIDTH'(1);
                if (sample_cnt_d == num_q) begin
                    state_d = S_DRAIN;
                end
            end else begin
                overflow_d = 1'b1;
            end
        end

        // Only the final sample is ever held in DRAIN, so its last channel closes the block.
        if ((state_q == S_DRAIN) && free_now) begin
            state_d = S_DONE;
        end

        if (arm && ((state_q == S_IDLE) || (state_q == S_DONE)) && (num_samples != '0)) begin
            state_d      = S_ARMED;
            num_d        = num_samples;
            sample_cnt_d = '0;
            overflow_d   = 1'b0;
        end

        if (abort) begin
            state_d     = S_IDLE;
            snap_full_d = 1'b0;
            ch_idx_d    = '0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            snap_q       <= '0;
            snap_full_q  <= 1'b0;
            ch_idx_q     <= '0;
            sample_cnt_q <= '0;
            num_q        <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            snap_full_q  <= snap_full_d;
            ch_idx_q     <= ch_idx_d;
            sample_cnt_q <= sample_cnt_d;
            num_q        <= num_d;
            overflow_q   <= overflow_d;
        end
    end

    assign m_tvalid = snap_full_q;
    assign m_tdata  = snap_q[ch_idx_q];
    assign m_tchan  = ch_idx_q;
    assign m_tlast  = snap_full_q & (ch_idx_q == LAST_CH) & (state_q == S_DRAIN);
    assign busy     = (state_q == S_ARMED) | (state_q == S_CAPTURE) | (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ad9228_capture_ctrl.sv
// Testbench for ad9228_capture_ctrl: directed scenarios with randomized data,
// strobe spacing and ready, checked each cycle against a transaction-level model.
module tb_ad9228_capture_ctrl;

    localparam int DW = 12;
    localparam int NC = 4;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NC*DW-1:0]  ch_data;
    logic              sample_strb;
    logic              arm;
    logic              trigger;
    logic              abort;
    logic [CW-1:0]     num_samples;
    logic [DW-1:0]     m_tdata;
    logic [1:0]        m_tchan;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic              busy;
    logic              done;
    logic              overflow;

    always #5 clk = ~clk;

    ad9228_capture_ctrl #(.DATA_WIDTH(DW), .NUM_CH(NC), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rstn(rstn), .ch_data(ch_data), .sample_strb(sample_strb),
        .arm(arm), .trigger(trigger), .abort(abort), .num_samples(num_samples),
        .m_tdata(m_tdata), .m_tchan(m_tchan), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .busy(busy), .done(done), .overflow(overflow)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: phase 0 idle, 1 armed, 2 capturing, 3 draining, 4 done.
    int          ph;
    int          n_lat;
    int          acc;
    int          pend;
    bit          cur_last;
    bit          m_ovf;
    logic [DW-1:0] cur [NC];
    int          beats;
    int          last_beat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int  p;
        int  nph;
        bit  take;
        if (!rstn) begin
            ph = 0; pend = 0; acc = 0; m_ovf = 0; cur_last = 0;
            for (int i = 0; i < NC; i++) cur[i] = '0;
        end else if (abort) begin
            ph = 0; pend = 0;
        end else begin
            take = (pend > 0) && m_tready;
            p    = pend - (take ? 1 : 0);
            nph  = ph;
            if (ph == 3 && take && pend == 1 && cur_last) nph = 4;
            if (ph == 2 || (ph == 1 && trigger)) begin
                if (ph == 1) nph = 2;
                if (sample_strb) begin
                    if (p == 0) begin
                        acc++;
                        for (int i = 0; i < NC; i++) cur[i] = ch_data[i*DW +: DW];
                        p = NC;
                        cur_last = (acc == n_lat);
                        if (cur_last) nph = 3;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
            if (arm && (ph == 0 || ph == 4) && num_samples != 0) begin
                nph = 1; n_lat = int'(num_samples); acc = 0; m_ovf = 0;
            end
            ph   = nph;
            pend = p;
        end
    endtask

    task automatic check_outputs();
        chk("tvalid", m_tvalid, (pend > 0));
        chk("busy", busy, (ph >= 1 && ph <= 3));
        chk("done", done, (ph == 4));
        chk("overflow", overflow, m_ovf);
        chk("tlast", m_tlast, (pend == 1 && cur_last));
        if (pend > 0) begin
            chk("tchan", m_tchan, NC - pend);
            chk("tdata", m_tdata, cur[NC - pend]);
        end
    endtask

    task automatic cycle();
        if (m_tvalid && m_tready) begin
            beats++;
            if (m_tlast) last_beat = beats;
        end
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_arm(input int n);
        num_samples = CW'(n);
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        beats = 0;
        last_beat = 0;
    endtask

    // mode 0: fixed A/B/C/D words, ready high; 1: random words, ready high; 2: random words and ready.
    task automatic run_acq(input int period, input int budget, input int mode, input string tag);
        int c;
        c = 0;
        while (!done && c < budget) begin
            sample_strb = (period > 0) && (c % period == 0);
            if (mode == 0) ch_data = {12'hD, 12'hC, 12'hB, 12'hA};
            else           ch_data = {$urandom, $urandom};
            m_tready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
            c++;
        end
        sample_strb = 1'b0;
        m_tready    = 1'b1;
        chk(tag, done, 1'b1);
    endtask

    initial begin
        rstn = 1'b0; ch_data = '0; sample_strb = 1'b0; arm = 1'b0; trigger = 1'b0;
        abort = 1'b0; num_samples = '0; m_tready = 1'b1;
        beats = 0; last_beat = 0; ph = 0; pend = 0; acc = 0; n_lat = 0; cur_last = 0; m_ovf = 0;
        for (int i = 0; i < NC; i++) cur[i] = '0;

        // Reset state
        cycle();
        cycle();
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tchan", m_tchan, 0);
        rstn = 1'b1;
        cycle();

        // Three samples, strobe every 6 cycles, fixed words
        do_arm(3);
        trigger = 1'b1;
        run_acq(6, 100, 0, "t1_done");
        trigger = 1'b0;
        chk("t1_beats", beats, 12);
        chk("t1_last_beat", last_beat, 12);
        chk("t1_overflow", overflow, 0);

        // Strobe every 2 cycles: drops expected
        do_arm(4);
        trigger = 1'b1;
        run_acq(2, 100, 1, "t2_done");
        trigger = 1'b0;
        chk("t2_overflow", overflow, 1);
        chk("t2_beats", beats, 16);

        // Strobe coincident with last-channel handshake
        do_arm(2);
        trigger = 1'b1;
        ch_data = {$urandom, $urandom};
        sample_strb = 1'b1;
        cycle();
        sample_strb = 1'b0;
        for (int k = 0; k < 10 && pend != 1; k++) cycle();
        chk("t3_at_ch3", m_tchan, 3);
        ch_data = {$urandom, $urandom};
        sample_strb = 1'b1;
        cycle();
        sample_strb = 1'b0;
        chk("t3_overflow", overflow, 0);
        chk("t3_tvalid", m_tvalid, 1);
        chk("t3_tchan", m_tchan, 0);
        run_acq(0, 20, 1, "t3_done");
        trigger = 1'b0;
        chk("t3_beats", beats, 8);

        // Ready held low for 10 cycles mid-sample
        do_arm(1);
        trigger = 1'b1;
        ch_data = {$urandom, $urandom};
        sample_strb = 1'b1;
        cycle();
        sample_strb = 1'b0;
        cycle();
        m_tready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("t4_stall_chan", m_tchan, 1);
        end
        m_tready = 1'b1;
        run_acq(0, 20, 1, "t4_done");
        trigger = 1'b0;
        chk("t4_beats", beats, 4);

        // Abort during capture with a full snapshot, then re-arm
        do_arm(5);
        trigger = 1'b1;
        m_tready = 1'b0;
        ch_data = {$urandom, $urandom};
        sample_strb = 1'b1;
        cycle();
        sample_strb = 1'b0;
        chk("t5_full", m_tvalid, 1);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        trigger = 1'b0;
        m_tready = 1'b1;
        chk("t5_tvalid", m_tvalid, 0);
        chk("t5_busy", busy, 0);
        do_arm(1);
        chk("t5_rearm_busy", busy, 1);
        trigger = 1'b1;
        run_acq(3, 40, 1, "t5_done");
        trigger = 1'b0;

        // arm with num_samples = 0 from IDLE
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        do_arm(0);
        cycle();
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);

        // Randomized acquisitions
        for (int r = 0; r < 5; r++) begin
            int n;
            n = $urandom_range(1, 5);
            do_arm(n);
            trigger = 1'b1;
            run_acq($urandom_range(1, 7), 400, 2, "rnd_done");
            trigger = 1'b0;
            chk("rnd_beats", beats, 4 * n);
        end

        // Reset while draining
        do_arm(1);
        trigger = 1'b1;
        m_tready = 1'b0;
        ch_data = {$urandom, $urandom};
        sample_strb = 1'b1;
        cycle();
        sample_strb = 1'b0;
        trigger = 1'b0;
        chk("t7_busy_before", busy, 1);
        rstn = 1'b0;
        cycle();
        chk("t7_tdata", m_tdata, 0);
        chk("t7_tchan", m_tchan, 0);
        chk("t7_tlast", m_tlast, 0);
        chk("t7_tvalid", m_tvalid, 0);
        chk("t7_busy", busy, 0);
        chk("t7_done", done, 0);
        chk("t7_overflow", overflow, 0);
        rstn = 1'b1;
        m_tready = 1'b1;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
